// File: rtl/fpu_writeback_arbiter_pkg.sv
// Shared FPU writeback types: register address/data widths and the
// {addr, data} result entry carried from the execution units to the regfile.
package fpu_writeback_arbiter_pkg;

  localparam int FREG_AW = 5;
  localparam int FDATA_W = 32;

  typedef struct packed {
    logic [FREG_AW-1:0] addr;
    logic [FDATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/fpu_writeback_arbiter_wb_fifo.sv
// wb_fifo: synchronous DEPTH-entry result FIFO (DEPTH power of two).
// Ports: clk, rst (sync, active-low), push/push_data, pop, head, empty, full.
import fpu_writeback_arbiter_pkg::*;

module wb_fifo #(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t push_data,
  input  logic      pop,
  output wb_entry_t head,
  output logic      empty,
  output logic      full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign head  = mem_q[rptr_q];

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    do_pop  = pop & ~empty;
    // A full FIFO still accepts when the head leaves in the same cycle.
    do_push = push & (~full | do_pop);
    if (do_push) begin
      mem_d[wptr_q] = push_data;
      wptr_d        = wptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rptr_d = rptr_q + PTR_W'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fpu_writeback_arbiter.sv
// FPU writeback arbiter: round-robin merge of two result ports into a FIFO,
// output stage to the regfile write port, and a busy scoreboard with queries.
import fpu_writeback_arbiter_pkg::*;

module fpu_writeback_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               src0_valid,
  output logic               src0_ready,
  input  logic [FREG_AW-1:0] src0_addr,
  input  logic [FDATA_W-1:0] src0_data,
  input  logic               src1_valid,
  output logic               src1_ready,
  input  logic [FREG_AW-1:0] src1_addr,
  input  logic [FDATA_W-1:0] src1_data,
  input  logic               issue_en,
  input  logic [FREG_AW-1:0] issue_addr,
  input  logic [FREG_AW-1:0] q_addr1,
  input  logic [FREG_AW-1:0] q_addr2,
  input  logic [FREG_AW-1:0] q_addr3,
  output logic               q_busy1,
  output logic               q_busy2,
  output logic               q_busy3,
  input  logic               wr_stall,
  output logic               we,
  output logic [FREG_AW-1:0] waddr,
  output logic [FDATA_W-1:0] wdata
);

  logic               last1_q, last1_d;
  logic               out_valid_q, out_valid_d;
  logic [FREG_AW-1:0] waddr_q, waddr_d;
  logic [FDATA_W-1:0] wdata_q, wdata_d;
  logic [31:0]        busy_q, busy_d;

  logic      gnt1;
  logic      can_load;
  logic      can_push;
  logic      push;
  logic      pop;
  wb_entry_t push_entry;
  wb_entry_t head;
  logic      fifo_empty;
  logic      fifo_full;

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .head     (head),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign we    = out_valid_q & ~wr_stall;
  assign waddr = waddr_q;
  assign wdata = wdata_q;

  always_comb begin
    can_load = ~out_valid_q | ~wr_stall;
    pop      = can_load & ~fifo_empty;
    can_push = ~fifo_full | pop;
    // src1 wins only if src0 is idle or src0 went last.
    gnt1       = src1_valid & (~src0_valid | ~last1_q);
    src0_ready = rst & ~gnt1 & can_push;
    src1_ready = rst & gnt1 & can_push;
    push       = (src0_valid & src0_ready) | (src1_valid & src1_ready);
    push_entry.addr = gnt1 ? src1_addr : src0_addr;
    push_entry.data = gnt1 ? src1_data : src0_data;
    last1_d = push ? gnt1 : last1_q;

    out_valid_d = out_valid_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    if (can_load) begin
      out_valid_d = ~fifo_empty;
      if (!fifo_empty) begin
        waddr_d = head.addr;
        wdata_d = head.data;
      end
    end

    // Clear first so an issue to the same register wins.
    busy_d = busy_q;
    if (we) begin
      busy_d[waddr_q] = 1'b0;
    end
    if (issue_en) begin
      busy_d[issue_addr] = 1'b1;
    end
  end

  assign q_busy1 = busy_q[q_addr1] & ~(we & (waddr_q == q_addr1));
  assign q_busy2 = busy_q[q_addr2] & ~(we & (waddr_q == q_addr2));
  assign q_busy3 = busy_q[q_addr3] & ~(we & (waddr_q == q_addr3));

  always_ff @(posedge clk) begin
    if (!rst) begin
      last1_q     <= 1'b1;
      out_valid_q <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      busy_q      <= '0;
    end else begin
      last1_q     <= last1_d;
      out_valid_q <= out_valid_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_fpu_writeback_arbiter.sv
// Scoreboard bench for fpu_writeback_arbiter: directed vectors, expected
// writes queued at issue and checked by an independent write monitor.
module tb_fpu_writeback_arbiter;
  import fpu_writeback_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        src0_valid, src0_ready;
  logic [4:0]  src0_addr;
  logic [31:0] src0_data;
  logic        src1_valid, src1_ready;
  logic [4:0]  src1_addr;
  logic [31:0] src1_data;
  logic        issue_en;
  logic [4:0]  issue_addr;
  logic [4:0]  q_addr1, q_addr2, q_addr3;
  logic        q_busy1, q_busy2, q_busy3;
  logic        wr_stall;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  int total = 0;
  int bad = 0;
  logic [36:0] exp_q[$];
  logic [36:0] mon_e;

  always #5 clk = ~clk;

  fpu_writeback_arbiter #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .src0_valid(src0_valid), .src0_ready(src0_ready),
    .src0_addr(src0_addr), .src0_data(src0_data),
    .src1_valid(src1_valid), .src1_ready(src1_ready),
    .src1_addr(src1_addr), .src1_data(src1_data),
    .issue_en(issue_en), .issue_addr(issue_addr),
    .q_addr1(q_addr1), .q_addr2(q_addr2), .q_addr3(q_addr3),
    .q_busy1(q_busy1), .q_busy2(q_busy2), .q_busy3(q_busy3),
    .wr_stall(wr_stall), .we(we), .waddr(waddr), .wdata(wdata)
  );

  task automatic check(input string nm, input logic [36:0] act,
                       input logic [36:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (we === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL wr_unexpected got=%h want=none", {waddr, wdata});
      end else begin
        mon_e = exp_q.pop_front();
        if ({waddr, wdata} !== mon_e) begin
          bad++;
          $display("FAIL wr_order got=%h want=%h", {waddr, wdata}, mon_e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int i0, i1, acc, k, g;
    rst = 1'b0;
    src0_valid = 0; src0_addr = 0; src0_data = 0;
    src1_valid = 0; src1_addr = 0; src1_data = 0;
    issue_en = 0; issue_addr = 0; wr_stall = 0;
    q_addr1 = 0; q_addr2 = 0; q_addr3 = 0;
    repeat (3) tick();

    src0_valid = 1; src1_valid = 1;
    #1;
    check("rst_rdy0", 37'(src0_ready), 37'd0);
    check("rst_rdy1", 37'(src1_ready), 37'd0);
    check("rst_we", 37'(we), 37'd0);
    check("rst_busy", 37'(q_busy1), 37'd0);
    src0_valid = 0; src1_valid = 0;
    rst = 1;
    tick();

    // single transfer, 2-cycle latency, one-cycle write
    src0_valid = 1; src0_addr = 5'd3; src0_data = 32'h3F80_0000;
    #1;
    check("t1_ready", 37'(src0_ready), 37'd1);
    exp_q.push_back({5'd3, 32'h3F80_0000});
    tick();
    src0_valid = 0;
    check("t1_we_early", 37'(we), 37'd0);
    tick();
    check("t1_we", 37'(we), 37'd1);
    check("t1_wr", {waddr, wdata}, {5'd3, 32'h3F80_0000});
    tick();
    check("t1_we_once", 37'(we), 37'd0);

    rst = 0; tick(); rst = 1; tick();

    // both sources valid: alternating grants starting at src0
    i0 = 0; i1 = 0;
    src0_valid = 1; src1_valid = 1;
    for (int i = 0; i < 4; i++) begin
      src0_addr = 5'(1 + i0); src0_data = 32'hA000_0000 + i0;
      src1_addr = 5'(16 + i1); src1_data = 32'hB000_0000 + i1;
      #1;
      g = i % 2;
      check("rr_rdy0", 37'(src0_ready), 37'(g == 0));
      check("rr_rdy1", 37'(src1_ready), 37'(g == 1));
      if (g == 0) begin
        exp_q.push_back({5'(1 + i0), 32'hA000_0000 + i0});
        i0++;
      end else begin
        exp_q.push_back({5'(16 + i1), 32'hB000_0000 + i1});
        i1++;
      end
      tick();
    end
    src0_valid = 0; src1_valid = 0;
    repeat (8) tick();

    // stall: 4 in FIFO + 1 in output stage
    wr_stall = 1; acc = 0; k = 0;
    for (int i = 0; i < 8; i++) begin
      src0_valid = (k < 6);
      src0_addr = 5'(20 + k); src0_data = 32'hC000_0000 + k;
      #1;
      if (src0_valid && src0_ready) begin
        exp_q.push_back({5'(20 + k), 32'hC000_0000 + k});
        acc++;
        k++;
      end
      tick();
    end
    check("stall_acc", 37'(acc), 37'd5);
    check("stall_rdy_low", 37'(src0_ready), 37'd0);
    src0_valid = 0; wr_stall = 0;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("drain_we", 37'(we), 37'd1);
      tick();
    end
    check("drain_end", 37'(we), 37'd0);
    repeat (2) tick();

    // scoreboard set / forwarding clear / set-wins
    q_addr1 = 5'd7; q_addr2 = 5'd8;
    issue_en = 1; issue_addr = 5'd7;
    tick();
    issue_en = 0;
    check("busy_set", 37'(q_busy1), 37'd1);
    check("busy_other", 37'(q_busy2), 37'd0);
    src0_valid = 1; src0_addr = 5'd7; src0_data = 32'h4049_0FDB;
    exp_q.push_back({5'd7, 32'h4049_0FDB});
    tick();
    src0_valid = 0;
    check("busy_pending", 37'(q_busy1), 37'd1);
    tick();
    check("busy_cwe", 37'(we), 37'd1);
    check("busy_fwd", 37'(q_busy1), 37'd0);
    tick();
    check("busy_clr", 37'(q_busy1), 37'd0);
    issue_en = 1; issue_addr = 5'd7;
    tick();
    issue_en = 0;
    src0_valid = 1; src0_addr = 5'd7; src0_data = 32'h4000_0000;
    exp_q.push_back({5'd7, 32'h4000_0000});
    tick();
    src0_valid = 0;
    tick();
    check("sw_we", 37'(we), 37'd1);
    issue_en = 1; issue_addr = 5'd7;
    tick();
    issue_en = 0;
    check("busy_set_wins", 37'(q_busy1), 37'd1);
    repeat (3) tick();

    // reset mid-operation discards everything
    for (int a = 0; a < 32; a++) begin
      issue_en = 1; issue_addr = 5'(a);
      tick();
    end
    issue_en = 0;
    q_addr1 = 5'd0; q_addr2 = 5'd17; q_addr3 = 5'd31;
    #1;
    check("all_b1", 37'(q_busy1), 37'd1);
    check("all_b2", 37'(q_busy2), 37'd1);
    check("all_b3", 37'(q_busy3), 37'd1);
    wr_stall = 1; acc = 0;
    for (int i = 0; i < 10 && acc < 4; i++) begin
      src0_valid = 1; src0_addr = 5'(24 + acc); src0_data = 32'hDEAD_0000 + acc;
      #1;
      if (src0_ready) acc++;
      tick();
    end
    check("rst_fill", 37'(acc), 37'd4);
    src0_valid = 1; src1_valid = 1;
    rst = 0;
    #1;
    check("mrst_rdy0", 37'(src0_ready), 37'd0);
    check("mrst_rdy1", 37'(src1_ready), 37'd0);
    tick();
    wr_stall = 0;
    #1;
    check("mrst_we", 37'(we), 37'd0);
    check("mrst_b1", 37'(q_busy1), 37'd0);
    check("mrst_b2", 37'(q_busy2), 37'd0);
    check("mrst_b3", 37'(q_busy3), 37'd0);
    src0_valid = 0; src1_valid = 0;
    rst = 1;
    repeat (10) tick();
    check("no_stale_b", 37'(q_busy3), 37'd0);
    check("sb_empty", 37'(exp_q.size()), 37'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
